// File: rtl/mealy_hit_counter.sv
// Windowed hit counter fed by a Mealy detector output: counts y over win_len-cycle windows
// and reports the total. Define HIT_SAT_EN to saturate the accumulator instead of wrapping.
module mealy_hit_counter #(
    parameter int          CNT_W  = 8,
    parameter int          WIN_W  = 8,
    parameter int unsigned THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic             y,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             burst,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             burst_q, burst_d;

    logic [WIN_W-1:0] win_load;
    logic [CNT_W-1:0] acc_inc;

    // win_len of 0 is treated as a one-cycle window; the timer counts down to 0.
    assign win_load = (win_len == '0) ? '0 : win_len - WIN_W'(1);

`ifdef HIT_SAT_EN
    assign acc_inc = (y && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;
`else
    assign acc_inc = acc_q + CNT_W'(y);
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        acc_d   = acc_q;
        count_d = count_q;
        valid_d = 1'b0;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    timer_d = win_load;
                    acc_d   = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    // Abort: the partial window is dropped and the last report is kept.
                    state_d = IDLE;
                    timer_d = '0;
                    acc_d   = '0;
                end else if (timer_q == '0) begin
                    // Final sample of the window is folded into the report; the next
                    // window starts clean on the following cycle.
                    count_d = acc_inc;
                    valid_d = 1'b1;
                    burst_d = (32'(acc_inc) >= 32'(THRESH));
                    timer_d = win_load;
                    acc_d   = '0;
                end else begin
                    timer_d = timer_q - WIN_W'(1);
                    acc_d   = acc_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            burst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            valid_q <= valid_d;
            burst_q <= burst_d;
        end
    end

    assign count_out = count_q;
    assign valid     = valid_q;
    assign burst     = burst_q;
    assign busy      = (state_q == RUN);

endmodule

// File: doc/mealy_hit_counter.md
MEALY_HIT_COUNTER -- requirements
Module: mealy_hit_counter

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the hit accumulator and count_out width.
REQ-002 Parameter WIN_W, default 8, SHALL set the win_len and window timer width.
REQ-003 Parameter THRESH, default 4, SHALL set the burst threshold (compared against the CNT_W-bit count).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 en  input  1  SHALL enable windowed counting; sampled every cycle.
REQ-007 win_len  input  WIN_W  SHALL give the window length in cycles; sampled only when a window starts.
REQ-008 y  input  1  SHALL be the hit input, driven by the upstream Mealy sequence detector output.
REQ-009 count_out  output  CNT_W  SHALL hold the hit count of the last completed window.
REQ-010 valid  output  1  SHALL pulse high for one cycle when count_out updates.
REQ-011 burst  output  1  SHALL be high while count_out >= THRESH.
REQ-012 busy  output  1  SHALL be high while the FSM is in RUN.

Function
REQ-013 FSM states SHALL be IDLE and RUN only.
REQ-014 IDLE with en=1 SHALL go to RUN next cycle:
  - load timer = max(win_len,1)-1
  - clear accumulator
REQ-015 Each RUN cycle SHALL add y (0 or 1) to the accumulator; every cycle with y=1 counts as one hit.
REQ-016 RUN with timer>0 SHALL decrement the timer.
REQ-017 Window end SHALL be the RUN cycle with timer=0 and en=1; that cycle's y is included.
REQ-018 On window end, next cycle SHALL show:
  - count_out = final accumulator value
  - burst = (that value >= THRESH)
  - valid = 1 for that cycle only
REQ-019 On window end, if en=1 the FSM SHALL stay in RUN:
  - reload the timer from the current win_len
  - accumulator restarts from the current cycle's... no: restarts at 0, so the first sample of the next window is the following cycle
  - no y sample is lost or double-counted between back-to-back windows
REQ-020 RUN with en=0, including on the final window cycle, SHALL:
  - abort to IDLE
  - discard the accumulator
  - produce no valid
  - leave count_out and burst unchanged
REQ-021 win_len=0 SHALL behave as win_len=1.
REQ-022 Report latency SHALL be one cycle after the last sampled y of the window.
REQ-023 count_out and burst SHALL hold their values between reports.
REQ-024 valid SHALL never be high in two consecutive cycles unless the window length is 1.

Reset
REQ-025 rst=1 SHALL force, on the next edge:
  - state = IDLE
  - timer = 0, accumulator = 0
  - count_out = 0, valid = 0, burst = 0, busy = 0
REQ-026 rst SHALL take priority over en and over window end, including mid-window; no valid is produced for an aborted window.

Configuration
REQ-027 Macro HIT_SAT_EN defined: the accumulator SHALL saturate at 2^CNT_W-1.
REQ-028 Macro HIT_SAT_EN undefined: the accumulator SHALL wrap modulo 2^CNT_W, and burst SHALL be computed on the wrapped value.

Verification
REQ-029 win_len=4, en held, y=1,0,1,1 -> valid 1 cycle after 4th sample, count_out=3, burst=0.
REQ-030 win_len=5, y=1 throughout, en held -> count_out=5, burst=1, valid every 5 cycles with no gap, busy stays 1.
REQ-031 en dropped on 3rd cycle of a win_len=4 window after a prior report of 3 -> no valid, count_out stays 3, busy=0 next cycle.
REQ-032 rst pulsed mid-window after count_out=5 -> all outputs 0 next cycle; no valid until a full new window completes.
REQ-033 CNT_W=3, win_len=10, y=1 throughout -> count_out=7 with HIT_SAT_EN, count_out=2 without.
REQ-034 win_len=0, en held, y=1 -> valid every cycle, count_out=1.
